// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: two requester command/response ports plus SRAM pins.
// slave modport = arbiter side, master modport = requesters + SRAM side.
interface sram_port_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic          req0_valid;
  logic          req0_write;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req0_lock;
  logic          req0_ready;
  logic          req0_rvalid;
  logic [DW-1:0] req0_rdata;
  logic          req1_valid;
  logic          req1_write;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          req1_lock;
  logic          req1_ready;
  logic          req1_rvalid;
  logic [DW-1:0] req1_rdata;
  logic          sram_csn;
  logic          sram_wen;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;
  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata, req0_lock,
    input  req1_valid, req1_write, req1_addr, req1_wdata, req1_lock,
    input  sram_q,
    output req0_ready, req0_rvalid, req0_rdata,
    output req1_ready, req1_rvalid, req1_rdata,
    output sram_csn, sram_wen, sram_a, sram_d
  );
  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata, req0_lock,
    output req1_valid, req1_write, req1_addr, req1_wdata, req1_lock,
    output sram_q,
    input  req0_ready, req0_rvalid, req0_rdata,
    input  req1_ready, req1_rvalid, req1_rdata,
    input  sram_csn, sram_wen, sram_a, sram_d
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin arbiter sharing one single-port SRAM between two requesters.
// Ports: hclk/hreset (sync, active high); bus = requester 0/1 commands, ready, read
// responses, and the registered SRAM pins (csn/wen/a/d out, q in).
module sram_port_arbiter #(
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic               hclk,
  input  logic               hreset,
  sram_port_arbiter_if.slave bus
);
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
  logic          w_v0, w_v1, w_any, w_sticky, w_gid;
  logic          w_write, w_lock;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          r_owner, r_locked;
  logic [7:0]    r_hold;
  logic          r_csn, r_wen;
  logic [AW-1:0] r_a;
  logic [DW-1:0] r_d;
  logic          r_rd, r_id, r_rv, r_rv_id;
  always_comb begin
    w_v0     = bus.req0_valid;
    w_v1     = bus.req1_valid;
    w_any    = w_v0 | w_v1;
    // owner keeps the port through a locked burst until it has used up its hold budget
    w_sticky = r_locked && (r_hold < HOLD_MAX);
    w_gid    = (w_v0 && w_v1) ? (w_sticky ? r_owner : !r_owner) : w_v1;
    w_write  = w_gid ? bus.req1_write : bus.req0_write;
    w_lock   = w_gid ? bus.req1_lock  : bus.req0_lock;
    w_addr   = w_gid ? bus.req1_addr  : bus.req0_addr;
    w_wdata  = w_gid ? bus.req1_wdata : bus.req0_wdata;
  end
  assign bus.req0_ready  = w_v0 && !w_gid;
  assign bus.req1_ready  = w_v1 && w_gid;
  assign bus.req0_rvalid = r_rv && !r_rv_id;
  assign bus.req1_rvalid = r_rv && r_rv_id;
  assign bus.req0_rdata  = bus.sram_q;
  assign bus.req1_rdata  = bus.sram_q;
  assign bus.sram_csn    = r_csn;
  assign bus.sram_wen    = r_wen;
  assign bus.sram_a      = r_a;
  assign bus.sram_d      = r_d;
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_owner  <= 1'b1;
      r_locked <= 1'b0;
      r_hold   <= 8'd0;
      r_csn    <= 1'b1;
      r_wen    <= 1'b1;
      r_a      <= '0;
      r_d      <= '0;
      r_rd     <= 1'b0;
      r_id     <= 1'b0;
      r_rv     <= 1'b0;
      r_rv_id  <= 1'b0;
    end else begin
      if (w_any) begin
        r_owner  <= w_gid;
        r_locked <= w_lock;
        r_hold   <= (w_gid != r_owner) ? 8'd1 : (r_hold < HOLD_MAX) ? r_hold + 8'd1 : r_hold;
        r_a      <= w_addr;
        r_d      <= w_wdata;
      end else begin
        r_locked <= 1'b0;
        r_hold   <= 8'd0;
      end
      r_csn   <= !w_any;
      r_wen   <= !(w_any && w_write);
      r_rd    <= w_any && !w_write;
      r_id    <= w_gid;
      // SRAM returns q one cycle after the read pins, so rvalid trails the SRAM stage by one
      r_rv    <= r_rd;
      r_rv_id <= r_id;
    end
  end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter that shares the single-port 4K x 32 SRAM between two independent command sources, e.g. the AHB-side SRAM controller path and a DMA/initialisation engine. It grants at most one access per cycle using round-robin with burst locking and a starvation bound. It registers the SRAM command pins and returns read data to the issuing requester with fixed latency.

## Interface
Parameters:
- AW, 12: SRAM address width.
- DW, 32: SRAM data width.
- MAX_HOLD, 16: maximum consecutive beats one requester may take while the other waits; legal range 1..255.

Ports. n = 0, 1; one set of request ports per requester.
- hclk  in  1  clock; all logic on rising edge.
- hreset  in  1  synchronous, active-high reset.
- reqn_valid  in  1  requester n has a command.
- reqn_write  in  1  1 = write, 0 = read.
- reqn_addr  in  AW  word address.
- reqn_wdata  in  DW  write data.
- reqn_lock  in  1  more beats of the same burst follow this one.
- reqn_ready  out  1  command accepted this cycle (valid & ready).
- reqn_rvalid  out  1  read data for requester n is on reqn_rdata.
- reqn_rdata  out  DW  read data; equals sram_q, qualified by rvalid.
- sram_csn  out  1  chip select, active low.
- sram_wen  out  1  write enable, active low.
- sram_a  out  AW  SRAM address.
- sram_d  out  DW  SRAM write data.
- sram_q  in  DW  SRAM read data, valid the cycle after a read access.

## Operation
- State: owner (last granted id), locked, hold_cnt (8 bit, saturates at MAX_HOLD).
- Grant is combinational from the valids and the registered state. reqn_ready never depends on itself.
  - No valid: no grant.
  - Exactly one valid: grant it. No lock or hold check applies.
  - Both valid, locked=1 and hold_cnt < MAX_HOLD: grant owner.
  - Both valid, otherwise: grant !owner (round-robin).
- On an accepted beat:
  - owner <= granted id.
  - locked <= granted reqn_lock.
  - hold_cnt <= hold_cnt+1 (saturating) if the granted id equals owner, else 1.
- Cycle with no accept: locked <= 0 and hold_cnt <= 0; owner is unchanged.
- SRAM stage: an accepted command registers onto sram_csn=0, sram_wen=!write, sram_a=addr, sram_d=wdata. The id and the is-read flag register alongside.
- Idle cycles drive sram_csn=1 and sram_wen=1. sram_a and sram_d hold their last values.
- Return stage: if the SRAM stage held a read, the following cycle asserts reqn_rvalid for the stored id only. rdata is sram_q, passed through combinationally.
- Writes produce no response. Ordering per requester is strictly issue order.

## Timing
- Reset values:
  - sram_csn=1, sram_wen=1, sram_a=0, sram_d=0.
  - req0_rvalid=0, req1_rvalid=0.
  - owner=1, so requester 0 wins the first tie.
  - locked=0, hold_cnt=0.
  - ready outputs follow the grant rule from the reset state.
- Accept in cycle N: SRAM pins active in N+1. For reads, rvalid and rdata arrive in N+2.
- Throughput: one access per cycle. Back-to-back reads or writes from either requester run with no bubbles.
- Read-after-write to the same address in consecutive beats returns the new data, because the SRAM write completes in N+1 and the read occurs in N+2.
- Hold bound: with both valid and the owner locked, the owner gets at most MAX_HOLD consecutive beats. The next beat goes to the other requester.
- Reset mid-operation: the reset edge clears the pipeline. Reads in flight return no rvalid and the SRAM is deselected in the following cycle. Requesters must reissue.
- A valid without ready must hold its command stable until accepted.

## Test plan
1. Reset, then both valid reads to addresses 0x010 and 0x020, lock=0, data preloaded A/B.
   - Required: req0 accepted cycle 1, req1 cycle 2.
   - Required: req0_rvalid with A at cycle 3, req1_rvalid with B at cycle 4.
2. Both continuously valid, lock=0.
   - Required: grants strictly alternate 0,1,0,1; sram_csn stays low every cycle.
3. req0 burst of 4 writes, lock=1 on beats 1-3; req1 valid throughout.
   - Required: req0 receives 4 consecutive grants, then req1 is granted.
   - Required: SRAM addresses written in order 0x100..0x103.
4. MAX_HOLD=16, req0 lock held for 40 beats, req1 valid.
   - Required: req1 granted exactly after every 16th req0 beat; no wait longer than 16 cycles.
5. Write 0xDEADBEEF to 0x0AB, then read 0x0AB the next cycle from the other requester.
   - Required: rvalid for the reader with 0xDEADBEEF two cycles after the read is accepted.
6. Assert hreset one cycle after a read is accepted.
   - Required: no rvalid; sram_csn=1, sram_wen=1, sram_a=0 the following cycle; requester 0 wins the next tie.
